// File: rtl/mem_load_unit.sv
// rtl/mem_load_unit.sv - memory-response stage: waits for a load response, extracts and extends its lane, forwards to decode
// Optional feature macro: MEM_LOAD_MISALIGN_CHK_EN (adds out_excp and misaligned-load trapping)
module mem_load_unit #(
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter int DEST_W = 5,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_allowin,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [AW-1:0]     in_addr,
  input  logic [DW-1:0]     in_alu_result,
  input  logic              in_is_load,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic              in_gr_we,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              data_rvalid,
  input  logic [DW-1:0]     data_rdata,
  output logic              out_valid,
  input  logic              out_allowin,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_gr_we,
  output logic [DEST_W-1:0] out_dest,
  output logic [DW-1:0]     out_result,
  output logic              fw_valid,
  output logic              fw_pending,
  output logic [DEST_W-1:0] fw_dest,
  output logic [DW-1:0]     fw_data
`ifdef MEM_LOAD_MISALIGN_CHK_EN
  ,
  output logic              out_excp
`endif
);

  localparam int LANE_W = $clog2(DW / 8);
  localparam logic [DW-1:0] M8  = DW'(8'hFF);
  localparam logic [DW-1:0] M16 = DW'(16'hFFFF);
  localparam logic [DW-1:0] M32 = DW'(32'hFFFF_FFFF);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              state_q;
  logic [PC_W-1:0]     pc_q;
  logic [LANE_W-1:0]   lane_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic                gr_we_q;
  logic [DEST_W-1:0]   dest_q;
  logic [DW-1:0]       result_q;
  logic [DW-1:0]       result_d;
  logic [LANE_W-1:0]   lane_sel;
  logic [DW-1:0]       shifted;
  logic                accept;
  logic                misalign;
  logic                fw_live;
  logic                unused_addr;

  // Only the lane-select bits of the address matter to this stage.
  assign unused_addr = ^in_addr[AW-1:LANE_W];

  assign in_allowin = !flush && ((state_q == S_EMPTY) ||
                                 ((state_q == S_READY) && out_allowin));
  assign accept     = in_valid && in_allowin;

`ifdef MEM_LOAD_MISALIGN_CHK_EN
  logic excp_q;

  // Misaligned loads never issue a bus request; they trap straight to READY.
  always_comb begin
    misalign = in_is_load &&
               (((in_size == 2'd1) && in_addr[0]) ||
                ((in_size == 2'd2) && (in_addr[1:0] != 2'b00)) ||
                ((in_size == 2'd3) && (in_addr[2:0] != 3'b000)));
  end

  assign out_excp = excp_q;
`else
  assign misalign = 1'b0;
`endif

  // Lane extraction: align the lane down to the access size, shift, then extend.
  always_comb begin
    lane_sel = lane_q;
    case (size_q)
      2'd1:    lane_sel = lane_q & ~LANE_W'(1);
      2'd2:    lane_sel = lane_q & ~LANE_W'(3);
      2'd3:    lane_sel = '0;
      default: lane_sel = lane_q;
    endcase
    shifted  = data_rdata >> {lane_sel, 3'b000};
    result_d = data_rdata;
    case (size_q)
      2'd0: begin
        result_d = shifted & M8;
        if (signed_q && shifted[7]) result_d = result_d | ~M8;
      end
      2'd1: begin
        result_d = shifted & M16;
        if (signed_q && shifted[15]) result_d = result_d | ~M16;
      end
      2'd2: begin
        result_d = shifted & M32;
        if (signed_q && shifted[31]) result_d = result_d | ~M32;
      end
      default: result_d = data_rdata;
    endcase
  end

  // Entry FSM and payload registers; accept wins over the per-state hold/drain moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_EMPTY;
      pc_q     <= '0;
      lane_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      gr_we_q  <= 1'b0;
      dest_q   <= '0;
      result_q <= '0;
`ifdef MEM_LOAD_MISALIGN_CHK_EN
      excp_q   <= 1'b0;
`endif
    end else if (accept) begin
      pc_q     <= in_pc;
      lane_q   <= in_addr[LANE_W-1:0];
      size_q   <= in_size;
      signed_q <= in_signed;
      gr_we_q  <= in_gr_we && !misalign;
      dest_q   <= in_dest;
`ifdef MEM_LOAD_MISALIGN_CHK_EN
      excp_q   <= misalign;
`endif
      if (in_is_load && !misalign) begin
        state_q  <= S_WAIT;
        result_q <= '0;
      end else begin
        state_q  <= S_READY;
        result_q <= in_is_load ? '0 : in_alu_result;
      end
    end else begin
      case (state_q)
        S_EMPTY: state_q <= S_EMPTY;
        S_WAIT: begin
          if (data_rvalid) begin
            if (flush) begin
              state_q <= S_EMPTY;
            end else begin
              state_q  <= S_READY;
              result_q <= result_d;
            end
          end else if (flush) begin
            state_q <= S_DRAIN;
          end
        end
        S_READY: begin
          if (flush || out_allowin) state_q <= S_EMPTY;
        end
        S_DRAIN: begin
          if (data_rvalid) state_q <= S_EMPTY;
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  assign out_valid  = (state_q == S_READY);
  assign out_pc     = pc_q;
  assign out_gr_we  = gr_we_q;
  assign out_dest   = dest_q;
  assign out_result = result_q;

  assign fw_live    = (state_q == S_WAIT) || (state_q == S_READY);
  assign fw_valid   = fw_live && gr_we_q;
  assign fw_pending = (state_q == S_WAIT);
  assign fw_dest    = fw_live ? dest_q : '0;
  assign fw_data    = fw_live ? result_q : '0;

endmodule

// File: tb/tb_mem_load_unit.sv
// tb/tb_mem_load_unit.sv - scoreboard bench for mem_load_unit (DW=32 main instance, DW=64 lane instance)
module tb_mem_load_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        flush, in_valid, in_allowin, in_is_load, in_signed, in_gr_we;
  logic [31:0] in_pc, in_addr, in_alu_result, data_rdata, out_pc, out_result, fw_data;
  logic [1:0]  in_size;
  logic [4:0]  in_dest, out_dest, fw_dest;
  logic        data_rvalid, out_valid, out_allowin, out_gr_we, fw_valid, fw_pending;

  logic        flush64, in_valid64, in_allowin64, in_is_load64, in_signed64, in_gr_we64;
  logic [31:0] in_pc64, in_addr64, out_pc64;
  logic [63:0] in_alu_result64, data_rdata64, out_result64, fw_data64;
  logic [1:0]  in_size64;
  logic [4:0]  in_dest64, out_dest64, fw_dest64;
  logic        data_rvalid64, out_valid64, out_allowin64, out_gr_we64, fw_valid64, fw_pending64;
`ifdef MEM_LOAD_MISALIGN_CHK_EN
  logic        out_excp, out_excp64;
`endif

  mem_load_unit #(.DW(32), .AW(32), .DEST_W(5), .PC_W(32)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_allowin(in_allowin),
    .in_pc(in_pc), .in_addr(in_addr), .in_alu_result(in_alu_result), .in_is_load(in_is_load),
    .in_size(in_size), .in_signed(in_signed), .in_gr_we(in_gr_we), .in_dest(in_dest),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata), .out_valid(out_valid),
    .out_allowin(out_allowin), .out_pc(out_pc), .out_gr_we(out_gr_we), .out_dest(out_dest),
    .out_result(out_result), .fw_valid(fw_valid), .fw_pending(fw_pending), .fw_dest(fw_dest),
    .fw_data(fw_data)
`ifdef MEM_LOAD_MISALIGN_CHK_EN
    , .out_excp(out_excp)
`endif
  );

  mem_load_unit #(.DW(64), .AW(32), .DEST_W(5), .PC_W(32)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush64), .in_valid(in_valid64), .in_allowin(in_allowin64),
    .in_pc(in_pc64), .in_addr(in_addr64), .in_alu_result(in_alu_result64), .in_is_load(in_is_load64),
    .in_size(in_size64), .in_signed(in_signed64), .in_gr_we(in_gr_we64), .in_dest(in_dest64),
    .data_rvalid(data_rvalid64), .data_rdata(data_rdata64), .out_valid(out_valid64),
    .out_allowin(out_allowin64), .out_pc(out_pc64), .out_gr_we(out_gr_we64), .out_dest(out_dest64),
    .out_result(out_result64), .fw_valid(fw_valid64), .fw_pending(fw_pending64), .fw_dest(fw_dest64),
    .fw_data(fw_data64)
`ifdef MEM_LOAD_MISALIGN_CHK_EN
    , .out_excp(out_excp64)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        gr_we;
    logic        excp;
    logic        chk_res;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] res,
                          input logic we, input logic excp, input logic chk_res);
    exp_t e;
    e.pc = pc; e.dest = dest; e.result = res; e.gr_we = we; e.excp = excp; e.chk_res = chk_res;
    sb_q.push_back(e);
  endtask

  // Reference lane extraction for DW=32.
  function automatic logic [31:0] ref_ld(input logic [1:0] sz, input logic sg,
                                         input logic [1:0] a, input logic [31:0] d);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = (d >> {a, 3'b000}) & 32'h0000_00FF;
        if (sg && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        v = (d >> {a[1], 4'b0000}) & 32'h0000_FFFF;
        if (sg && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  // Scoreboard monitor: every completed hand-off must match the head of the queue.
  always @(negedge clk) begin
    if (!reset && out_valid && out_allowin) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_out", 64'(1), 64'(0));
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_pc", 64'(out_pc), 64'(mon_e.pc));
        check("sb_dest", 64'(out_dest), 64'(mon_e.dest));
        check("sb_gr_we", 64'(out_gr_we), 64'(mon_e.gr_we));
        if (mon_e.chk_res) check("sb_result", 64'(out_result), 64'(mon_e.result));
`ifdef MEM_LOAD_MISALIGN_CHK_EN
        check("sb_excp", 64'(out_excp), 64'(mon_e.excp));
`endif
      end
    end
  end

  task automatic issue(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] alu,
                       input logic ld, input logic [1:0] sz, input logic sg, input logic we,
                       input logic [4:0] dst);
    int n;
    in_pc = pc; in_addr = addr; in_alu_result = alu; in_is_load = ld;
    in_size = sz; in_signed = sg; in_gr_we = we; in_dest = dst; in_valid = 1'b1;
    n = 0;
    while (!in_allowin && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_allowin) check("issue_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic respond(input int dly, input logic [31:0] rd);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check("fw_pending_wait", 64'(fw_pending), 64'(1));
      @(posedge clk); #1;
    end
    data_rdata = rd; data_rvalid = 1'b1;
    @(posedge clk); #1;
    data_rvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic ld64(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                      input logic sg, input logic [63:0] rd, input logic [63:0] exp);
    check("d64_allowin", 64'(in_allowin64), 64'(1));
    in_addr64 = addr; in_size64 = sz; in_signed64 = sg; in_is_load64 = 1'b1;
    in_gr_we64 = 1'b1; in_dest64 = 5'd1; in_pc64 = 32'h600; in_valid64 = 1'b1;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
    data_rdata64 = rd; data_rvalid64 = 1'b1;
    @(posedge clk); #1;
    data_rvalid64 = 1'b0;
    @(negedge clk);
    check("d64_out_valid", 64'(out_valid64), 64'(1));
    check(tag, out_result64, exp);
    @(posedge clk); #1;
  endtask

  logic [1:0]  r_sz, r_a;
  logic        r_sg;
  logic [31:0] r_rd, r_pc;
  int          r_dly;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_addr = '0; in_alu_result = '0;
    in_is_load = 1'b0; in_size = '0; in_signed = 1'b0; in_gr_we = 1'b0; in_dest = '0;
    data_rvalid = 1'b0; data_rdata = '0; out_allowin = 1'b1;
    flush64 = 1'b0; in_valid64 = 1'b0; in_pc64 = '0; in_addr64 = '0; in_alu_result64 = '0;
    in_is_load64 = 1'b0; in_size64 = '0; in_signed64 = 1'b0; in_gr_we64 = 1'b0; in_dest64 = '0;
    data_rvalid64 = 1'b0; data_rdata64 = '0; out_allowin64 = 1'b1;
    idle(2);
    @(negedge clk);
    check("rst_in_allowin", 64'(in_allowin), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_fw_valid", 64'(fw_valid), 64'(0));
    check("rst_fw_pending", 64'(fw_pending), 64'(0));
    check("rst_out_result", 64'(out_result), 64'(0));
    check("rst_out_pc", 64'(out_pc), 64'(0));
    check("rst64_in_allowin", 64'(in_allowin64), 64'(1));
    @(posedge clk); #1;
    reset = 1'b0;

    // Non-load passes straight through in one cycle, then the stage empties.
    push_exp(32'h100, 5'd3, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
    issue(32'h100, 32'h0, 32'h1234_5678, 1'b0, 2'd2, 1'b0, 1'b1, 5'd3);
    @(negedge clk);
    check("alu_out_valid", 64'(out_valid), 64'(1));
    check("alu_fw_data", 64'(fw_data), 64'h1234_5678);
    check("alu_fw_pending", 64'(fw_pending), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("alu_then_empty", 64'(out_valid), 64'(0));
    check("alu_empty_allowin", 64'(in_allowin), 64'(1));
    check("alu_empty_fw_valid", 64'(fw_valid), 64'(0));
    @(posedge clk); #1;

    // Loads with lane extraction.
    push_exp(32'h104, 5'd4, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b1);
    issue(32'h104, 32'h1003, 32'h0, 1'b1, 2'd0, 1'b1, 1'b1, 5'd4);
    @(negedge clk);
    check("lb_fw_dest", 64'(fw_dest), 64'(4));
    check("lb_allowin_wait", 64'(in_allowin), 64'(0));
    @(posedge clk); #1;
    respond(3, 32'h80FF_0000);
    push_exp(32'h108, 5'd5, 32'h0000_0080, 1'b1, 1'b0, 1'b1);
    issue(32'h108, 32'h1003, 32'h0, 1'b1, 2'd0, 1'b0, 1'b1, 5'd5);
    respond(1, 32'h80FF_0000);
    push_exp(32'h10C, 5'd6, 32'hFFFF_8001, 1'b1, 1'b0, 1'b1);
    issue(32'h10C, 32'h2002, 32'h0, 1'b1, 2'd1, 1'b1, 1'b1, 5'd6);
    respond(2, 32'h8001_1234);
    push_exp(32'h110, 5'd7, 32'h0000_1234, 1'b1, 1'b0, 1'b1);
    issue(32'h110, 32'h2000, 32'h0, 1'b1, 2'd1, 1'b0, 1'b1, 5'd7);
    respond(0, 32'h8001_1234);
    push_exp(32'h114, 5'd8, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
    issue(32'h114, 32'h2004, 32'h0, 1'b1, 2'd2, 1'b1, 1'b1, 5'd8);
    respond(1, 32'hDEAD_BEEF);
    idle(1);

    // Randomised mix of aligned loads and ALU ops.
    for (int k = 0; k < 16; k++) begin
      r_pc = 32'h400 + 32'(k * 4);
      r_rd = $urandom;
      if (k % 4 == 3) begin
        push_exp(r_pc, 5'(k), r_rd, 1'b1, 1'b0, 1'b1);
        issue(r_pc, 32'h0, r_rd, 1'b0, 2'd2, 1'b0, 1'b1, 5'(k));
      end else begin
        r_sz  = 2'($urandom_range(0, 2));
        r_sg  = 1'($urandom_range(0, 1));
        r_a   = 2'($urandom_range(0, 3));
        r_dly = int'($urandom_range(0, 3));
        if (r_sz == 2'd1) r_a[0] = 1'b0;
        if (r_sz == 2'd2) r_a = 2'b00;
        push_exp(r_pc, 5'(k), ref_ld(r_sz, r_sg, r_a, r_rd), 1'b1, 1'b0, 1'b1);
        issue(r_pc, {30'h0, r_a}, 32'h0, 1'b1, r_sz, r_sg, 1'b1, 5'(k));
        respond(r_dly, r_rd);
      end
    end
    idle(2);

    // Writeback back-pressure: outputs hold, then back-to-back hand-off.
    out_allowin = 1'b0;
    push_exp(32'h200, 5'd9, 32'hAAAA_0001, 1'b1, 1'b0, 1'b1);
    issue(32'h200, 32'h0, 32'hAAAA_0001, 1'b0, 2'd2, 1'b0, 1'b1, 5'd9);
    push_exp(32'h204, 5'd10, 32'hBBBB_0002, 1'b0, 1'b0, 1'b1);
    in_pc = 32'h204; in_alu_result = 32'hBBBB_0002; in_is_load = 1'b0; in_gr_we = 1'b0;
    in_dest = 5'd10; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_out_valid", 64'(out_valid), 64'(1));
      check("stall_out_pc", 64'(out_pc), 64'h200);
      check("stall_out_result", 64'(out_result), 64'hAAAA_0001);
      check("stall_in_allowin", 64'(in_allowin), 64'(0));
      @(posedge clk); #1;
    end
    out_allowin = 1'b1;
    @(negedge clk);
    check("release_in_allowin", 64'(in_allowin), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("handoff_out_valid", 64'(out_valid), 64'(1));
    check("handoff_out_pc", 64'(out_pc), 64'h204);
    check("handoff_fw_valid", 64'(fw_valid), 64'(0));
    idle(2);

    // Flush in WAIT; the late response is dropped in DRAIN.
    issue(32'h300, 32'h0, 32'h0, 1'b1, 2'd2, 1'b0, 1'b1, 5'd11);
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_allowin", 64'(in_allowin), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("drain_in_allowin", 64'(in_allowin), 64'(0));
    check("drain_fw_valid", 64'(fw_valid), 64'(0));
    check("drain_fw_pending", 64'(fw_pending), 64'(0));
    check("drain_fw_dest", 64'(fw_dest), 64'(0));
    check("drain_out_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    data_rdata = 32'h5555_AAAA; data_rvalid = 1'b1;
    @(negedge clk);
    check("drain2_in_allowin", 64'(in_allowin), 64'(0));
    @(posedge clk); #1;
    data_rvalid = 1'b0;
    @(negedge clk);
    check("drain_done_allowin", 64'(in_allowin), 64'(1));
    check("drain_done_out_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;

    // Flush coincident with the response.
    issue(32'h310, 32'h0, 32'h0, 1'b1, 2'd2, 1'b0, 1'b1, 5'd12);
    flush = 1'b1; data_rvalid = 1'b1; data_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    flush = 1'b0; data_rvalid = 1'b0;
    @(negedge clk);
    check("flushrv_out_valid", 64'(out_valid), 64'(0));
    check("flushrv_in_allowin", 64'(in_allowin), 64'(1));
    @(posedge clk); #1;

    // Reset while a response is outstanding; a stray response afterwards is ignored.
    issue(32'h320, 32'h0, 32'h0, 1'b1, 2'd2, 1'b0, 1'b1, 5'd13);
    @(negedge clk);
    check("rstw_fw_valid", 64'(fw_valid), 64'(1));
    check("rstw_fw_dest", 64'(fw_dest), 64'(13));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstw_in_allowin", 64'(in_allowin), 64'(1));
    check("rstw_fw_pending", 64'(fw_pending), 64'(0));
    check("rstw_out_pc", 64'(out_pc), 64'(0));
    check("rstw_out_dest", 64'(out_dest), 64'(0));
    check("rstw_out_gr_we", 64'(out_gr_we), 64'(0));
    @(posedge clk); #1;
    data_rvalid = 1'b1;
    @(posedge clk); #1;
    data_rvalid = 1'b0;
    @(negedge clk);
    check("stray_rv_out_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;

`ifdef MEM_LOAD_MISALIGN_CHK_EN
    // Misaligned word load traps without waiting for a response.
    push_exp(32'h500, 5'd14, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(32'h500, 32'h2, 32'h0, 1'b1, 2'd2, 1'b0, 1'b1, 5'd14);
    @(negedge clk);
    check("mis_out_valid", 64'(out_valid), 64'(1));
    check("mis_out_excp", 64'(out_excp), 64'(1));
    check("mis_out_gr_we", 64'(out_gr_we), 64'(0));
    check("mis_fw_valid", 64'(fw_valid), 64'(0));
    check("mis_fw_pending", 64'(fw_pending), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("mis_then_empty", 64'(in_allowin), 64'(1));
    @(posedge clk); #1;
`endif

    // DW=64 lane extraction.
    ld64("d64_lw_signed", 32'h4, 2'd2, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000);
    ld64("d64_lw_unsigned", 32'h4, 2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000);
    ld64("d64_ld", 32'h0, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    ld64("d64_lb_lane7", 32'h7, 2'd0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    ld64("d64_lh_lane6", 32'h6, 2'd1, 1'b1, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
    ld64("d64_lhu_lane2", 32'h2, 2'd1, 1'b0, 64'h0000_0000_BEEF_0000, 64'h0000_0000_0000_BEEF);

    idle(3);
    check("sb_leftover", 64'(sb_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
